fifo_rd_packer: RTL and testbench

- Read-side consumer of async_fifo_top, in the rclk domain. It pops bytes from the FIFO read port (pop/rdata/empty) and packs NBYTES consecutive bytes into one wide word.
- It presents each word on a valid/ready output interface to the downstream datapath.
- A flush input forces out a partially filled word, tagged with its byte count.

---
 rtl/fifo_rd_packer.sv | 101 ++++++++++
 tb/tb_fifo_rd_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Packs NBYTES consecutive bytes popped from an async FIFO read port into one
// wide word on a valid/ready interface; flush emits a partial word with its byte count.
module fifo_rd_packer #(
    parameter int DWIDTH = 8,
    parameter int NBYTES = 4,
    parameter int CNTW   = 3
) (
    input  logic                     rclk,
    input  logic                     reset,
    input  logic                     empty,
    input  logic [DWIDTH-1:0]        rdata,
    output logic                     pop,
    input  logic                     flush,
    output logic [DWIDTH*NBYTES-1:0] out_data,
    output logic [CNTW-1:0]          out_bytes,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_t;

    localparam logic [CNTW-1:0] FULL   = CNTW'(NBYTES);
    localparam logic [CNTW:0]   FULL_X = (CNTW+1)'(NBYTES);

    state_t                          state_q, state_d;
    logic [NBYTES-1:0][DWIDTH-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]                 acc_cnt_q, acc_cnt_d;
    logic                            pop_d_q;
    logic [DWIDTH*NBYTES-1:0]        out_data_q, out_data_d;
    logic [CNTW-1:0]                 out_bytes_q, out_bytes_d;
    logic                            out_valid_q, out_valid_d;
    logic                            out_free, load;

    // Counting the byte still in flight keeps the accumulator from overflowing.
    assign pop = !reset && !empty && (state_q == RUN) &&
                 (({1'b0, acc_cnt_q} + {{CNTW{1'b0}}, pop_d_q}) < FULL_X);

    assign out_free = !out_valid_q || out_ready;
    // A full accumulator always leaves as a word; EMIT forces out a partial one.
    assign load     = out_free && ((acc_cnt_q == FULL) || (state_q == EMIT));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        if (pop_d_q) begin
            for (int i = 0; i < NBYTES; i++)
                if (acc_cnt_q == CNTW'(i))
                    acc_d[i] = rdata;
            acc_cnt_d = acc_cnt_q + CNTW'(1);
        end

        // Lanes are zeroed on every load, so a partial word has clean upper lanes.
        if (load) begin
            out_data_d  = acc_q;
            out_bytes_d = acc_cnt_q;
            out_valid_d = 1'b1;
            acc_cnt_d   = '0;
            acc_d       = '0;
        end

        unique case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   state_d = (acc_cnt_d != '0) ? EMIT : RUN;
            EMIT:    if (load) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q     <= RUN;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            pop_d_q     <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            pop_d_q     <= pop;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a byte-array FIFO model with 1-cycle read latency feeds
// the DUT; expected words go on a scoreboard queue and are compared against accepted words.
module tb_fifo_rd_packer;

    localparam int DWIDTH = 8;
    localparam int NBYTES = 4;
    localparam int CNTW   = 3;
    localparam int WW     = DWIDTH*NBYTES + CNTW;

    logic                     rclk = 1'b0;
    logic                     reset = 1'b1;
    logic                     empty;
    logic [DWIDTH-1:0]        rdata = '0;
    logic                     pop;
    logic                     flush = 1'b0;
    logic [DWIDTH*NBYTES-1:0] out_data;
    logic [CNTW-1:0]          out_bytes;
    logic                     out_valid;
    logic                     out_ready = 1'b1;

    int total = 0, bad = 0;
    int got_n = 0, gidx = 0, pop_cnt = 0, vld_cnt = 0, viol = 0;
    int wr_ptr = 0, rd_ptr = 0;
    logic [7:0]    src [0:255];
    logic [WW-1:0] got [0:63];
    logic [WW-1:0] exp_q [$];

    fifo_rd_packer #(.DWIDTH(DWIDTH), .NBYTES(NBYTES), .CNTW(CNTW)) dut (
        .rclk(rclk), .reset(reset), .empty(empty), .rdata(rdata), .pop(pop),
        .flush(flush), .out_data(out_data), .out_bytes(out_bytes),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 rclk = ~rclk;

    assign empty = (wr_ptr == rd_ptr);

    always @(posedge rclk)
        if (pop) begin
            rdata  <= src[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end

    always @(negedge rclk)
        if (!reset) begin
            if (pop) pop_cnt <= pop_cnt + 1;
            if (pop && empty) viol <= viol + 1;
            if (out_valid) vld_cnt <= vld_cnt + 1;
            if (out_valid && out_ready) begin
                got[got_n[5:0]] <= {out_data, out_bytes};
                got_n <= got_n + 1;
            end
        end

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        src[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [31:0] d, input int n);
        exp_q.push_back({d, CNTW'(n)});
    endtask

    task automatic wait_words(input int n);
        for (int c = 0; c < 200 && got_n < n; c++) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        total += 4;
        if (pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b want 0", pop); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        if (out_bytes !== '0) begin bad++; $display("FAIL reset_bytes: got %0d want 0", out_bytes); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int p0, v0;
        logic [WW-1:0] w;
        p0 = pop_cnt; v0 = vld_cnt;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_word(32'h44332211, 4);
        wait_words(gidx + exp_q.size());
        repeat (4) tick();
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL basic_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL basic_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
        total += 2;
        if (pop_cnt - p0 != 4) begin bad++; $display("FAIL basic_pops: got %0d want 4", pop_cnt - p0); end
        if (vld_cnt - v0 != 1) begin bad++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cnt - v0); end
    endtask

    task automatic test_backpressure;
        int p0;
        logic [WW-1:0] w;
        p0 = pop_cnt;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (25) tick();
        total += 4;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        if (out_data !== 32'h04030201) begin bad++; $display("FAIL bp_hold_data: got %h want 04030201", out_data); end
        if (pop_cnt - p0 != 8) begin bad++; $display("FAIL bp_pops: got %0d want 8", pop_cnt - p0); end
        if (pop !== 1'b0) begin bad++; $display("FAIL bp_pop_stopped: got %b want 0", pop); end
        expect_word(32'h04030201, 4);
        expect_word(32'h08070605, 4);
        out_ready = 1'b1;
        wait_words(gidx + exp_q.size());
        repeat (4) tick();
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL bp_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL bp_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
        total++;
        if (got_n != gidx) begin bad++; $display("FAIL bp_extra_words: got %0d want %0d", got_n, gidx); end
    endtask

    task automatic test_flush_partial;
        logic [WW-1:0] w;
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (8) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        expect_word(32'h00CCBBAA, 3);
        wait_words(gidx + exp_q.size());
        repeat (8) tick();
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL flush_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL flush_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
        total++;
        if (got_n != gidx) begin bad++; $display("FAIL flush_one_word: got %0d words want %0d", got_n, gidx); end
    endtask

    task automatic test_flush_inflight;
        int v0;
        logic [WW-1:0] w;
        push(8'h5A);
        repeat (5) tick();
        push(8'h5B);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        expect_word(32'h00005B5A, 2);
        wait_words(gidx + exp_q.size());
        repeat (4) tick();
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL inflight_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL inflight_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
        v0 = vld_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (8) tick();
        total++;
        if (vld_cnt != v0) begin bad++; $display("FAIL flush_empty_valid: got %0d cycles want 0", vld_cnt - v0); end
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        expect_word(32'hC4C3C2C1, 4);
        wait_words(gidx + exp_q.size());
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL flush_empty_resume: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL flush_empty_resume: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
    endtask

    task automatic test_empty_stall;
        int p0, v0;
        logic [WW-1:0] w;
        p0 = pop_cnt; v0 = vld_cnt;
        push(8'hD1); push(8'hD2);
        repeat (12) tick();
        total += 3;
        if (pop_cnt - p0 != 2) begin bad++; $display("FAIL stall_pops: got %0d want 2", pop_cnt - p0); end
        if (vld_cnt != v0) begin bad++; $display("FAIL stall_valid: got %0d cycles want 0", vld_cnt - v0); end
        if (pop !== 1'b0) begin bad++; $display("FAIL stall_pop: got %b want 0", pop); end
        push(8'hD3); push(8'hD4);
        expect_word(32'hD4D3D2D1, 4);
        wait_words(gidx + exp_q.size());
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL stall_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL stall_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [WW-1:0] w;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(8'hB0 + 8'(i));
        repeat (20) tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
        reset = 1'b1; tick(); reset = 1'b0;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        if (out_data !== '0) begin bad++; $display("FAIL rmid_data: got %h want 0", out_data); end
        if (out_bytes !== '0) begin bad++; $display("FAIL rmid_bytes: got %0d want 0", out_bytes); end
        if (pop !== 1'b0) begin bad++; $display("FAIL rmid_pop: got %b want 0", pop); end
        out_ready = 1'b1;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        expect_word(32'hE4E3E2E1, 4);
        wait_words(gidx + exp_q.size());
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL rmid_fresh_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL rmid_fresh_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [WW-1:0] w;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) push(8'(16*k + i + 32));
            expect_word({8'(16*k+35), 8'(16*k+34), 8'(16*k+33), 8'(16*k+32)}, 4);
        end
        wait_words(gidx + exp_q.size());
        repeat (4) tick();
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front(); total++;
            if (gidx >= got_n) begin bad++; $display("FAIL b2b_word: got none want %h", w); end
            else begin
                if (got[gidx[5:0]] !== w) begin bad++; $display("FAIL b2b_word: got %h want %h", got[gidx[5:0]], w); end
                gidx++;
            end
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL pop_while_empty: got %0d want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_partial();
        test_flush_inflight();
        test_empty_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
